usr_cmd_sequencer: RTL

- Command front-end placed directly upstream of the universal shift register (USR).
- Accepts one register operation at a time over a valid/ready handshake: parallel load, shift by K toward LSB, shift by K toward MSB, or no-op.
- Drives the USR control pins (mode, p_data, sin_left, sin_right) for the required number of cycles.
- Reads back the USR's Q and returns it as a captured result with a one-cycle done pulse.

---
 rtl/usr_cmd_sequencer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/usr_cmd_sequencer.sv
// rtl/usr_cmd_sequencer.sv - command sequencer driving a universal shift register (optional rotate: USR_SEQ_ROTATE_EN)
module usr_cmd_sequencer #(
    parameter int N     = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [N-1:0]     cmd_data,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic             cmd_fill,
`ifdef USR_SEQ_ROTATE_EN
    input  logic             cmd_rot,
`endif
    input  logic [N-1:0]     q_in,
    output logic [1:0]       mode,
    output logic [N-1:0]     p_data,
    output logic             sin_left,
    output logic             sin_right,
    output logic             busy,
    output logic             done,
    output logic [N-1:0]     result
);

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_SHR  = 2'b01;  // toward LSB, serial bit enters MSB
    localparam logic [1:0] OP_SHL  = 2'b10;  // toward MSB, serial bit enters LSB
    localparam logic [1:0] OP_LOAD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_RUN    = 2'b01,
        S_SETTLE = 2'b10,
        S_DONE   = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [N-1:0]     data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fill_q, fill_d;
    logic             rot_q, rot_d;
    logic             rot_in;
    logic [1:0]       mode_q, mode_d;
    logic [N-1:0]     p_data_q, p_data_d;
    logic             sin_left_q, sin_left_d;
    logic             sin_right_q, sin_right_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [N-1:0]     result_q, result_d;

`ifdef USR_SEQ_ROTATE_EN
    assign rot_in = cmd_rot;
`else
    assign rot_in = 1'b0;
`endif

    // Ready is the only unregistered output; it must drop the instant reset asserts.
    assign cmd_ready = (state_q == S_IDLE) && rst;

    // Next-state, command latching and registered output values for the next cycle.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        fill_d      = fill_q;
        rot_d       = rot_q;
        result_d    = result_q;
        mode_d      = 2'b00;
        p_data_d    = '0;
        sin_left_d  = 1'b0;
        sin_right_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_d   = cmd_op;
                    data_d = cmd_data;
                    cnt_d  = cmd_cnt;
                    fill_d = cmd_fill;
                    rot_d  = rot_in;
                    if (cmd_op == OP_LOAD) begin
                        state_d = S_RUN;
                        cnt_d   = CNT_W'(1);
                    end else if ((cmd_op != OP_NOP) && (cmd_cnt != '0)) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_SETTLE;
                    end
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                // Q has absorbed the last active cycle by now
                result_d = q_in;
                state_d  = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are computed from the state being entered so they line up with it.
        if (state_d == S_RUN) begin
            mode_d      = op_d;
            p_data_d    = (op_d == OP_LOAD) ? data_d : '0;
            sin_left_d  = (op_d == OP_SHR) && !rot_d && fill_d;
            sin_right_d = (op_d == OP_SHL) && !rot_d && fill_d;
        end
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State, latched command and registered outputs; reset aborts any command in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            op_q        <= 2'b00;
            data_q      <= '0;
            cnt_q       <= '0;
            fill_q      <= 1'b0;
            rot_q       <= 1'b0;
            mode_q      <= 2'b00;
            p_data_q    <= '0;
            sin_left_q  <= 1'b0;
            sin_right_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            fill_q      <= fill_d;
            rot_q       <= rot_d;
            mode_q      <= mode_d;
            p_data_q    <= p_data_d;
            sin_left_q  <= sin_left_d;
            sin_right_q <= sin_right_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            result_q    <= result_d;
        end
    end

    // In rotate mode the bit leaving one end of Q feeds straight back into the other.
    assign sin_left  = (rot_q && (state_q == S_RUN) && (op_q == OP_SHR)) ? q_in[0]   : sin_left_q;
    assign sin_right = (rot_q && (state_q == S_RUN) && (op_q == OP_SHL)) ? q_in[N-1] : sin_right_q;

    assign mode   = mode_q;
    assign p_data = p_data_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
